// File: rtl/alu_seq.sv
// Multicycle ALU: single-cycle add/sub/logic, iterative one-bit-per-cycle shifts, start/done handshake.
// Define ALU_SEQ_MUL_EN to compile in the WIDTH-cycle unsigned shift-add multiplier as op 8.
module alu_seq #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;
   localparam logic [3:0] OP_SRL = 4'd6;
   localparam logic [3:0] OP_SRA = 4'd7;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] val;
      logic             cout;
   } shift_t;

   // One shift step; cout is the bit that falls off the end.
   function automatic shift_t shift1(input logic [3:0] sop, input logic [WIDTH-1:0] x);
      shift_t s;
      if (sop == OP_SLL) begin
         s.val  = {x[WIDTH-2:0], 1'b0};
         s.cout = x[WIDTH-1];
      end else if (sop == OP_SRL) begin
         s.val  = {1'b0, x[WIDTH-1:1]};
         s.cout = x[0];
      end else begin
         s.val  = {x[WIDTH-1], x[WIDTH-1:1]};
         s.cout = x[0];
      end
      return s;
   endfunction

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
      return {(r == '0), r[WIDTH-1], c, v};
   endfunction

   state_t             state, state_nxt;
   logic [3:0]         op_q, op_nxt;
   logic [WIDTH-1:0]   sh_q, sh_nxt;
   logic [SHAMT_W-1:0] cnt_q, cnt_nxt;
   logic [WIDTH-1:0]   result_nxt;
   logic [3:0]         flags_nxt;
   logic               done_nxt, illegal_nxt;

   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     sum_w, diff_w;
   shift_t             stp;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] prod_q, prod_nxt, mcand_q, mcand_nxt, prod_sum;
   logic [WIDTH-1:0]   mplier_q, mplier_nxt;
`endif

   assign busy = (state != S_IDLE);

   always_comb begin
      // NOTE: every always_comb output and temporary gets a default first, so no path can infer a latch.
      state_nxt   = state;
      op_nxt      = op_q;
      sh_nxt      = sh_q;
      cnt_nxt     = cnt_q;
      result_nxt  = result;
      flags_nxt   = flags;
      done_nxt    = 1'b0;
      illegal_nxt = 1'b0;
      shamt       = b[SHAMT_W-1:0];
      sum_w       = {1'b0, a} + {1'b0, b};
      diff_w      = {1'b0, a} - {1'b0, b};
      stp         = shift1(op, a);
`ifdef ALU_SEQ_MUL_EN
      prod_nxt    = prod_q;
      mcand_nxt   = mcand_q;
      mplier_nxt  = mplier_q;
      prod_sum    = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

      case (state)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_ADD: begin
                     result_nxt = sum_w[WIDTH-1:0];
                     flags_nxt  = mk_flags(sum_w[WIDTH-1:0], sum_w[WIDTH],
                                           (a[WIDTH-1] == b[WIDTH-1]) &&
                                           (sum_w[WIDTH-1] != a[WIDTH-1]));
                     done_nxt   = 1'b1;
                  end
                  OP_SUB: begin
                     // Top bit of the widened difference is the unsigned borrow.
                     result_nxt = diff_w[WIDTH-1:0];
                     flags_nxt  = mk_flags(diff_w[WIDTH-1:0], diff_w[WIDTH],
                                           (a[WIDTH-1] != b[WIDTH-1]) &&
                                           (diff_w[WIDTH-1] != a[WIDTH-1]));
                     done_nxt   = 1'b1;
                  end
                  OP_AND: begin
                     result_nxt = a & b;
                     flags_nxt  = mk_flags(a & b, 1'b0, 1'b0);
                     done_nxt   = 1'b1;
                  end
                  OP_OR: begin
                     result_nxt = a | b;
                     flags_nxt  = mk_flags(a | b, 1'b0, 1'b0);
                     done_nxt   = 1'b1;
                  end
                  OP_XOR: begin
                     result_nxt = a ^ b;
                     flags_nxt  = mk_flags(a ^ b, 1'b0, 1'b0);
                     done_nxt   = 1'b1;
                  end
                  OP_SLL, OP_SRL, OP_SRA: begin
                     if (shamt == '0) begin
                        result_nxt = a;
                        flags_nxt  = mk_flags(a, 1'b0, 1'b0);
                        done_nxt   = 1'b1;
                     end else if (shamt == SHAMT_W'(1)) begin
                        result_nxt = stp.val;
                        flags_nxt  = mk_flags(stp.val, stp.cout, 1'b0);
                        done_nxt   = 1'b1;
                     end else begin
                        // The accepting edge already performs the first step.
                        op_nxt    = op;
                        sh_nxt    = stp.val;
                        cnt_nxt   = shamt - SHAMT_W'(1);
                        state_nxt = S_SHIFT;
                     end
                  end
`ifdef ALU_SEQ_MUL_EN
                  OP_MUL: begin
                     prod_nxt   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
                     mcand_nxt  = {{(WIDTH-1){1'b0}}, a, 1'b0};
                     mplier_nxt = {1'b0, b[WIDTH-1:1]};
                     cnt_nxt    = SHAMT_W'(WIDTH-1);
                     state_nxt  = S_MUL;
                  end
`endif
                  default: begin
                     result_nxt  = '0;
                     done_nxt    = 1'b1;
                     illegal_nxt = 1'b1;
                  end
               endcase
            end
         end

         S_SHIFT: begin
            stp     = shift1(op_q, sh_q);
            sh_nxt  = stp.val;
            cnt_nxt = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_nxt = stp.val;
               flags_nxt  = mk_flags(stp.val, stp.cout, 1'b0);
               done_nxt   = 1'b1;
               state_nxt  = S_IDLE;
            end
         end

`ifdef ALU_SEQ_MUL_EN
         S_MUL: begin
            prod_nxt   = prod_sum;
            mcand_nxt  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_nxt = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_nxt    = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_nxt = prod_sum[WIDTH-1:0];
               flags_nxt  = mk_flags(prod_sum[WIDTH-1:0], |prod_sum[2*WIDTH-1:WIDTH], 1'b0);
               done_nxt   = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
`endif

         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         result  <= '0;
         flags   <= '0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         result  <= result_nxt;
         flags   <= flags_nxt;
         done    <= done_nxt;
         illegal <= illegal_nxt;
      end
   end

   // NOTE: working registers need no reset; each is loaded on acceptance before it is ever read.
   always_ff @(posedge clk) begin
      op_q     <= op_nxt;
      sh_q     <= sh_nxt;
      cnt_q    <= cnt_nxt;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= prod_nxt;
      mcand_q  <= mcand_nxt;
      mplier_q <= mplier_nxt;
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed scenarios then random ops against an arithmetic reference model.
module tb_alu_seq;
   localparam int W  = 16;
   localparam int SW = $clog2(W);

   logic         clk = 1'b0;
   logic         rst, start;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, illegal;
   logic [W-1:0] result;
   logic [3:0]   flags;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .illegal(illegal), .result(result), .flags(flags)
   );

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
      logic         ill;
      int           due;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [3:0] mflags = 4'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic; latency from the op class.
   task automatic predict(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int base);
      exp_t   e;
      int     ux, uy, sx, sy, s, n, lat;
      longint p;
      logic   c, v, legal;
      logic [W-1:0] r;
      ux = int'(x);  uy = int'(y);
      sx = int'($signed(x));  sy = int'($signed(y));
      n = int'(y[SW-1:0]);
      c = 1'b0; v = 1'b0; legal = 1'b1; lat = 1; r = '0;
      case (o)
         4'd0: begin s = ux + uy; r = s[W-1:0]; c = (s > 65535);
                     v = (sx + sy > 32767) || (sx + sy < -32768); end
         4'd1: begin s = ux - uy; r = s[W-1:0]; c = (ux < uy);
                     v = (sx - sy > 32767) || (sx - sy < -32768); end
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd5: begin r = x << n; c = (n == 0) ? 1'b0 : x[W-n]; lat = (n < 2) ? 1 : n; end
         4'd6: begin r = x >> n; c = (n == 0) ? 1'b0 : x[n-1]; lat = (n < 2) ? 1 : n; end
         4'd7: begin r = $signed(x) >>> n; c = (n == 0) ? 1'b0 : x[n-1]; lat = (n < 2) ? 1 : n; end
`ifdef ALU_SEQ_MUL_EN
         4'd8: begin p = longint'(ux) * longint'(uy); r = p[W-1:0]; c = ((p >> W) != 0); lat = W; end
`endif
         default: legal = 1'b0;
      endcase
      if (legal) mflags = {(r == '0), r[W-1], c, v};
      e.res = legal ? r : '0;
      e.flg = mflags;
      e.ill = !legal;
      e.due = base + lat;
      sbq.push_back(e);
   endtask

   // Drives one request on a falling edge once the DUT is idle; leaves start high for the accepting edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int guard = 0;
      @(negedge clk);
      start = 1'b0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("busy_timeout", busy, 0);
      op = o; a = x; b = y; start = 1'b1;
      predict(o, x, y, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (illegal && !done) check("illegal_without_done", illegal, 0);
         if (done) begin
            if (sbq.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               e = sbq.pop_front();
               check("result", result, e.res);
               check("flags", flags, e.flg);
               check("illegal", illegal, e.ill);
               check("done_cycle", cyc, e.due);
               check("busy_at_done", busy, 0);
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            check("done_missing", done, 1);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      int guard;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      issue(4'd0, 16'h7FFF, 16'h0001);
      issue(4'd1, 16'h0003, 16'h0005);
      issue(4'd2, 16'hF0F0, 16'h3C3C);
      issue(4'd7, 16'h8004, 16'd3);
      @(negedge clk);
      start = 1'b0;
      check("sra_busy_c1", busy, 1);
      start = 1'b1; op = 4'd0; a = 16'h1234; b = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      check("sra_busy_c2", busy, 1);

      issue(4'd5, 16'h0001, 16'd0);
      issue(4'd5, 16'h0001, 16'd15);
      issue(4'd8, 16'h0100, 16'h0100);
      issue(4'd12, 16'hFFFF, 16'hFFFF);
      issue(4'd6, 16'h8001, 16'd1);

      issue(4'd6, 16'hFFFF, 16'd10);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("srl_busy_before_rst", busy, 1);
      rst = 1'b1;
      sbq.delete();
      mflags = 4'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_illegal", illegal, 0);
      check("midrst_result", result, 0);
      check("midrst_flags", flags, 0);
      @(negedge clk);
      rst = 1'b0;
      issue(4'd0, 16'h0001, 16'h0001);

      for (int i = 0; i < 300; i++) begin
         logic [3:0]   o;
         logic [W-1:0] x, y;
         o = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
         x = W'($urandom);
         y = W'($urandom);
         case ($urandom_range(0, 7))
            0: x = 16'h8000;
            1: y = 16'hFFFF;
            2: x = 16'h0000;
            default: ;
         endcase
         issue(o, x, y);
         if ($urandom_range(0, 5) == 0) begin
            @(negedge clk);
            start = 1'b0;
         end
      end

      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (sbq.size() > 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("queue_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
